// File: rtl/io_atomic_sequencer.sv
`default_nettype none
//==============================================================================
// Module : io_atomic_sequencer
// Turns one core LR/SC/AMO request into the tagged Wishbone phases io_bus expects.
// Rev    : 1.0
//==============================================================================
`ifndef ADDR_TAG_BITS
`define ADDR_TAG_BITS 2
`endif
`ifndef ADDR_TAG_NONE
`define ADDR_TAG_NONE 2'd0
`endif
`ifndef ADDR_TAG_MODE_LRSC
`define ADDR_TAG_MODE_LRSC 2'd1
`endif
`ifndef ADDR_TAG_MODE_AMO
`define ADDR_TAG_MODE_AMO 2'd2
`endif

module io_atomic_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   input  logic [3:0]                op_i,
   input  logic [31:0]               addr_i,
   input  logic [31:0]               wdata_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [31:0]               rdata_o,
   output logic                      stb_o,
   output logic                      cyc_o,
   output logic [31:0]               addr_o,
   output logic [`ADDR_TAG_BITS-1:0] addr_tag_o,
   output logic [31:0]               bus_data_o,
   output logic [3:0]                sel_o,
   output logic                      we_o,
   input  logic                      ack_i,
   input  logic                      err_i,
   input  logic [31:0]               bus_data_i,
   input  logic                      data_tag_i
);
   localparam logic [3:0] c_OP_LR   = 4'd0;
   localparam logic [3:0] c_OP_SC   = 4'd1;
   localparam logic [3:0] c_OP_SWAP = 4'd2;
   localparam logic [3:0] c_OP_ADD  = 4'd3;
   localparam logic [3:0] c_OP_XOR  = 4'd4;
   localparam logic [3:0] c_OP_AND  = 4'd5;
   localparam logic [3:0] c_OP_OR   = 4'd6;
   localparam logic [3:0] c_OP_MIN  = 4'd7;
   localparam logic [3:0] c_OP_MAX  = 4'd8;
   localparam logic [3:0] c_OP_MINU = 4'd9;
   localparam logic [3:0] c_OP_MAXU = 4'd10;

   localparam int              c_CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CALC = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   logic [3:0]      r_op;
   logic [31:0]     r_wdata;
   logic [31:0]     r_old;
   logic [c_CW-1:0] r_cnt;
   logic            r_bad;

   logic            w_req_bad;
   logic            w_timeout;
   logic            w_fin;
   logic            w_fin_err;
   logic [31:0]     w_fin_data;
   logic [31:0]     w_amo;

   assign sel_o     = 4'hF;
   assign w_req_bad = (addr_i[1:0] != 2'b00) || (op_i > c_OP_MAXU);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TO_LAST);

   always_comb begin
      w_amo = r_wdata;
      case (r_op)
         c_OP_SWAP: w_amo = r_wdata;
         c_OP_ADD:  w_amo = r_old + r_wdata;
         c_OP_XOR:  w_amo = r_old ^ r_wdata;
         c_OP_AND:  w_amo = r_old & r_wdata;
         c_OP_OR:   w_amo = r_old | r_wdata;
         c_OP_MIN:  w_amo = ($signed(r_old) < $signed(r_wdata)) ? r_old : r_wdata;
         c_OP_MAX:  w_amo = ($signed(r_old) > $signed(r_wdata)) ? r_old : r_wdata;
         c_OP_MINU: w_amo = (r_old < r_wdata) ? r_old : r_wdata;
         c_OP_MAXU: w_amo = (r_old > r_wdata) ? r_old : r_wdata;
         default:   w_amo = r_wdata;
      endcase
   end

   // Every exit into DONE is decided here; an error always beats a same-cycle ack.
   always_comb begin
      w_fin      = 1'b0;
      w_fin_err  = 1'b0;
      w_fin_data = 32'h0;
      case (r_state)
         S_RD: begin
            if (err_i) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end else if (ack_i) begin
               if (r_op == c_OP_LR) begin
                  w_fin      = 1'b1;
                  w_fin_data = bus_data_i;
               end
            end else if (w_timeout) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end
         end
         S_WR: begin
            if (err_i) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end else if (ack_i) begin
               w_fin      = 1'b1;
               w_fin_data = (r_op == c_OP_SC) ? {31'b0, data_tag_i} : r_old;
            end else if (w_timeout) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end
         end
         S_CALC: begin
            if (r_bad) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_op       <= 4'h0;
         r_wdata    <= 32'h0;
         r_old      <= 32'h0;
         r_cnt      <= '0;
         r_bad      <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         rdata_o    <= 32'h0;
         stb_o      <= 1'b0;
         cyc_o      <= 1'b0;
         we_o       <= 1'b0;
         addr_o     <= 32'h0;
         addr_tag_o <= `ADDR_TAG_NONE;
         bus_data_o <= 32'h0;
      end else begin
         done_o <= 1'b0;
         if (w_fin) begin
            r_state    <= S_DONE;
            stb_o      <= 1'b0;
            cyc_o      <= 1'b0;
            we_o       <= 1'b0;
            addr_tag_o <= `ADDR_TAG_NONE;
            done_o     <= 1'b1;
            err_o      <= w_fin_err;
            rdata_o    <= w_fin_data;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (req_i) begin
                     r_op    <= op_i;
                     r_wdata <= wdata_i;
                     addr_o  <= addr_i;
                     busy_o  <= 1'b1;
                     r_cnt   <= '0;
                     // Rejected requests spend one bus-idle cycle in CALC before reporting.
                     if (w_req_bad) begin
                        r_bad   <= 1'b1;
                        r_state <= S_CALC;
                     end else if (op_i == c_OP_SC) begin
                        r_state    <= S_WR;
                        stb_o      <= 1'b1;
                        cyc_o      <= 1'b1;
                        we_o       <= 1'b1;
                        bus_data_o <= wdata_i;
                        addr_tag_o <= `ADDR_TAG_MODE_LRSC;
                     end else begin
                        r_state    <= S_RD;
                        stb_o      <= 1'b1;
                        cyc_o      <= 1'b1;
                        we_o       <= 1'b0;
                        addr_tag_o <= (op_i == c_OP_LR) ? `ADDR_TAG_MODE_LRSC : `ADDR_TAG_MODE_AMO;
                     end
                  end
               end
               S_RD: begin
                  if (ack_i) begin
                     r_old   <= bus_data_i;
                     stb_o   <= 1'b0;
                     r_state <= S_CALC;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_CALC: begin
                  r_state    <= S_WR;
                  stb_o      <= 1'b1;
                  we_o       <= 1'b1;
                  bus_data_o <= w_amo;
                  r_cnt      <= '0;
               end
               S_WR: begin
                  r_cnt <= r_cnt + 1'b1;
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  busy_o  <= 1'b0;
                  err_o   <= 1'b0;
                  rdata_o <= 32'h0;
                  r_bad   <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_io_atomic_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_io_atomic_sequencer
// Directed and randomized atomics compared cycle by cycle against a trace model.
// Rev    : 1.0
//==============================================================================
`ifndef ADDR_TAG_BITS
`define ADDR_TAG_BITS 2
`endif
`ifndef ADDR_TAG_NONE
`define ADDR_TAG_NONE 2'd0
`endif
`ifndef ADDR_TAG_MODE_LRSC
`define ADDR_TAG_MODE_LRSC 2'd1
`endif
`ifndef ADDR_TAG_MODE_AMO
`define ADDR_TAG_MODE_AMO 2'd2
`endif

module tb_io_atomic_sequencer;
   localparam int TO = 4;
   localparam bit [`ADDR_TAG_BITS-1:0] T_NONE = `ADDR_TAG_NONE;
   localparam bit [`ADDR_TAG_BITS-1:0] T_LRSC = `ADDR_TAG_MODE_LRSC;
   localparam bit [`ADDR_TAG_BITS-1:0] T_AMO  = `ADDR_TAG_MODE_AMO;

   logic clk_i = 1'b0;
   logic rst_i, req_i, ack_i, err_i, data_tag_i;
   logic [3:0] op_i;
   logic [31:0] addr_i, wdata_i, bus_data_i;
   logic busy_o, done_o, err_o, stb_o, cyc_o, we_o;
   logic [31:0] rdata_o, addr_o, bus_data_o;
   logic [`ADDR_TAG_BITS-1:0] addr_tag_o;
   logic [3:0] sel_o;

   always #5 clk_i = ~clk_i;

   io_atomic_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .rdata_o(rdata_o), .stb_o(stb_o), .cyc_o(cyc_o), .addr_o(addr_o),
      .addr_tag_o(addr_tag_o), .bus_data_o(bus_data_o), .sel_o(sel_o), .we_o(we_o),
      .ack_i(ack_i), .err_i(err_i), .bus_data_i(bus_data_i), .data_tag_i(data_tag_i)
   );

   // One entry per clock: inputs to drive, then outputs expected in that cycle.
   typedef struct packed {
      bit rst; bit req; bit [3:0] op; bit [31:0] addr; bit [31:0] wdata;
      bit ack; bit err; bit dtag; bit [31:0] rd;
      bit busy; bit stb; bit cyc; bit we; bit done;
      bit chk_tag; bit [`ADDR_TAG_BITS-1:0] tag; bit [31:0] eaddr;
      bit chk_wd; bit [31:0] wd; bit e_err; bit [31:0] e_rdata;
   } cyc_t;

   cyc_t q[$];
   int total = 0, bad = 0, cyc_n = 0;
   int obs_stb, obs_wrs, obs_rds, obs_done, done_at, t0;
   logic [31:0] obs_rdata, obs_wd;
   logic obs_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_n, act, exp);
      end
   endtask

   function automatic bit [31:0] amo(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
      case (op)
         4'd3:    return a + b;
         4'd4:    return a ^ b;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return ($signed(a) < $signed(b)) ? a : b;
         4'd8:    return ($signed(a) > $signed(b)) ? a : b;
         4'd9:    return (a < b) ? a : b;
         4'd10:   return (a > b) ? a : b;
         default: return b;
      endcase
   endfunction

   // Non-strobe cycle: random junk on every input, stray acks/errors included.
   function automatic cyc_t base(input bit busy);
      cyc_t c;
      c = '0;
      c.req = busy;
      c.op = 4'($urandom_range(0, 15));
      c.addr = $urandom;
      c.wdata = $urandom;
      c.rd = $urandom;
      c.dtag = 1'($urandom_range(0, 1));
      c.ack = ($urandom_range(0, 3) == 0);
      c.err = ($urandom_range(0, 5) == 0);
      c.busy = busy;
      c.chk_tag = !busy;
      c.tag = T_NONE;
      return c;
   endfunction

   function automatic cyc_t stbc(input bit we, input bit [`ADDR_TAG_BITS-1:0] tg,
                                 input bit [31:0] a, input bit [31:0] wd);
      cyc_t c;
      c = base(1'b1);
      c.ack = 1'b0; c.err = 1'b0;
      c.stb = 1'b1; c.cyc = 1'b1; c.we = we;
      c.chk_tag = 1'b1; c.tag = tg; c.eaddr = a;
      c.chk_wd = we; c.wd = wd;
      return c;
   endfunction

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) q.push_back(base(1'b0));
   endtask

   task automatic push_done(input bit e, input bit [31:0] d);
      cyc_t c;
      c = base(1'b1);
      c.done = 1'b1; c.e_err = e; c.e_rdata = e ? 32'h0 : d;
      q.push_back(c);
   endtask

   // kind: 0 ack, 1 err, 2 ack+err. waits >= TO means the slave never answers.
   task automatic phase(input bit we, input bit [`ADDR_TAG_BITS-1:0] tg, input bit [31:0] a,
                        input bit [31:0] wd, input int waits, input int kind, input bit [31:0] rdv,
                        input bit dt, output bit ok, output bit [31:0] got);
      cyc_t c;
      if (waits >= TO) begin
         for (int i = 0; i < TO; i++) q.push_back(stbc(we, tg, a, wd));
         ok = 1'b0; got = 32'h0;
      end else begin
         for (int i = 0; i < waits; i++) q.push_back(stbc(we, tg, a, wd));
         c = stbc(we, tg, a, wd);
         c.ack = (kind != 1); c.err = (kind != 0); c.rd = rdv; c.dtag = dt;
         q.push_back(c);
         ok = (kind == 0);
         got = we ? {31'b0, dt} : rdv;
      end
   endtask

   task automatic txn(input bit [3:0] op, input bit [31:0] a, input bit [31:0] wdata,
                      input int w1, input int k1, input bit [31:0] rdv,
                      input int w2, input int k2, input bit dt, input bit rst_wr);
      cyc_t c;
      bit ok;
      bit [31:0] got;
      bit [`ADDR_TAG_BITS-1:0] tg;
      c = base(1'b0);
      c.req = 1'b1; c.op = op; c.addr = a; c.wdata = wdata;
      q.push_back(c);
      if (a[1:0] != 2'b00 || op > 4'd10) begin
         q.push_back(base(1'b1));
         push_done(1'b1, 32'h0);
         return;
      end
      tg = (op <= 4'd1) ? T_LRSC : T_AMO;
      if (op == 4'd1) begin
         if (rst_wr) begin
            q.push_back(stbc(1'b1, tg, a, wdata));
            c = stbc(1'b1, tg, a, wdata);
            c.rst = 1'b1;
            q.push_back(c);
            return;
         end
         phase(1'b1, tg, a, wdata, w2, k2, 32'h0, dt, ok, got);
         push_done(!ok, got);
         return;
      end
      phase(1'b0, tg, a, 32'h0, w1, k1, rdv, 1'b0, ok, got);
      if (op == 4'd0 || !ok) begin
         push_done(!ok, got);
         return;
      end
      c = base(1'b1);
      c.cyc = 1'b1;
      q.push_back(c);
      phase(1'b1, tg, a, amo(op, rdv, wdata), w2, k2, 32'h0, dt, ok, got);
      push_done(!ok, rdv);
   endtask

   task automatic reset_obs();
      obs_stb = 0; obs_wrs = 0; obs_rds = 0; obs_done = 0; done_at = -1;
      obs_rdata = 32'h0; obs_wd = 32'h0; obs_err = 1'b0;
      t0 = cyc_n;
   endtask

   task automatic play();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk_i);
         #1;
         rst_i = c.rst; req_i = c.req; op_i = c.op; addr_i = c.addr; wdata_i = c.wdata;
         ack_i = c.ack; err_i = c.err; bus_data_i = c.rd; data_tag_i = c.dtag;
         @(negedge clk_i);
         cyc_n++;
         chk("busy", busy_o, c.busy);
         chk("stb", stb_o, c.stb);
         chk("cyc", cyc_o, c.cyc);
         chk("done", done_o, c.done);
         if (c.stb) begin
            chk("we", we_o, c.we);
            chk("addr", addr_o, c.eaddr);
            chk("sel", sel_o, 4'hF);
         end
         if (c.chk_tag) chk("tag", addr_tag_o, c.tag);
         if (c.chk_wd) chk("wdata", bus_data_o, c.wd);
         if (c.done) begin
            chk("err", err_o, c.e_err);
            chk("rdata", rdata_o, c.e_rdata);
         end
         if (stb_o) obs_stb++;
         if (stb_o && ack_i && !we_o) obs_rds++;
         if (stb_o && we_o) begin
            obs_wd = bus_data_o;
            if (ack_i) obs_wrs++;
         end
         if (done_o) begin
            obs_done++; obs_rdata = rdata_o; obs_err = err_o; done_at = cyc_n;
         end
      end
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b0; op_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
      ack_i = 1'b0; err_i = 1'b0; bus_data_i = 32'h0; data_tag_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_busy", busy_o, 0);   chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);     chk("rst_rdata", rdata_o, 0);
      chk("rst_stb", stb_o, 0);     chk("rst_cyc", cyc_o, 0);
      chk("rst_we", we_o, 0);       chk("rst_addr", addr_o, 0);
      chk("rst_bdata", bus_data_o, 0);
      chk("rst_tag", addr_tag_o, T_NONE);

      reset_obs();
      txn(4'd0, 32'h0010_0008, 32'h0, 0, 0, 32'h1234, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("lr_rdata", obs_rdata, 32'h1234); chk("lr_err", obs_err, 0);
      chk("lr_reads", obs_rds, 1); chk("lr_writes", obs_wrs, 0); chk("lr_latency", done_at - t0, 3);

      reset_obs();
      txn(4'd1, 32'h0010_0008, 32'h5, 0, 0, 32'h0, 0, 0, 1'b1, 1'b0); push_idle(1); play();
      chk("sc1_rdata", obs_rdata, 1); chk("sc1_wdata", obs_wd, 5); chk("sc1_writes", obs_wrs, 1);
      reset_obs();
      txn(4'd1, 32'h0010_0008, 32'h5, 0, 0, 32'h0, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("sc0_rdata", obs_rdata, 0); chk("sc0_err", obs_err, 0);

      reset_obs();
      txn(4'd3, 32'h0010_0004, 32'h2, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("add_wdata", obs_wd, 32'h1); chk("add_rdata", obs_rdata, 32'hFFFF_FFFF);
      chk("add_latency", done_at - t0, 5);

      reset_obs();
      txn(4'd7, 32'h0010_0004, 32'h1, 0, 0, 32'h8000_0000, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("min_wdata", obs_wd, 32'h8000_0000);
      reset_obs();
      txn(4'd9, 32'h0010_0004, 32'h1, 0, 0, 32'h8000_0000, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("minu_wdata", obs_wd, 32'h1);

      reset_obs();
      txn(4'd0, 32'h0010_0002, 32'h0, 0, 0, 32'h0, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("misal_stb", obs_stb, 0); chk("misal_err", obs_err, 1); chk("misal_latency", done_at - t0, 3);
      reset_obs();
      txn(4'd12, 32'h0010_0008, 32'h0, 0, 0, 32'h0, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("illop_stb", obs_stb, 0); chk("illop_err", obs_err, 1); chk("illop_latency", done_at - t0, 3);

      reset_obs();
      txn(4'd0, 32'h0010_0008, 32'h0, 10, 0, 32'h0, 0, 0, 1'b0, 1'b0); push_idle(1); play();
      chk("to_err", obs_err, 1); chk("to_stb_cycles", obs_stb, TO);

      reset_obs();
      txn(4'd1, 32'h0010_0008, 32'h7, 0, 0, 32'h0, 0, 0, 1'b0, 1'b1); push_idle(4); play();
      chk("rst_wr_done", obs_done, 0);

      for (int n = 0; n < 250; n++) begin
         bit [3:0] op;
         bit [31:0] a;
         int w1, w2, k1, k2;
         op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         w1 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         w2 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
         k1 = $urandom_range(0, 9); k1 = (k1 < 8) ? 0 : k1 - 7;
         k2 = $urandom_range(0, 9); k2 = (k2 < 8) ? 0 : k2 - 7;
         txn(op, a, $urandom, w1, k1, $urandom, w2, k2, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
         push_idle($urandom_range(0, 2));
         play();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
